// File: rtl/radar_sweep_ctrl.sv
// Radar pointing-angle controller: encoder-driven MANUAL mode, timer-driven SWEEP mode,
// and a frame-latched servo PWM generator.
module radar_sweep_ctrl #(
    parameter int ANGLE_MAX   = 180,
    parameter int ANGLE_STEP  = 1,
    parameter int SWEEP_DIV   = 500000,
    parameter int PWM_PERIOD  = 1000000,
    parameter int PWM_MIN     = 50000,
    parameter int PWM_PER_DEG = 278
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cw,
    input  logic       ccw,
    input  logic       mode_btn,
    output logic [7:0] angle,
    output logic       sweep_mode,
    output logic       dir,
    output logic       step,
    output logic       pwm
);
    localparam int SW = $clog2(SWEEP_DIV);
    localparam logic [7:0]    A_MAX   = 8'(ANGLE_MAX);
    localparam logic [7:0]    A_MID   = 8'(ANGLE_MAX / 2);
    localparam logic [8:0]    A_STEP9 = 9'(ANGLE_STEP);
    localparam logic [SW-1:0] SW_LAST = SW'(SWEEP_DIV - 1);
    localparam logic [19:0]   P_LAST  = 20'(PWM_PERIOD - 1);
    localparam logic [19:0]   P_MIN   = 20'(PWM_MIN);
    localparam logic [19:0]   P_DEG   = 20'(PWM_PER_DEG);

    typedef enum logic {MANUAL = 1'b0, SWEEP = 1'b1} state_t;

    state_t        state_reg;
    logic          mode_btn_reg;
    logic [SW-1:0] sweep_cnt_reg;
    logic [7:0]    angle_reg;
    logic          dir_reg;
    logic          step_reg;
    logic          pwm_reg;
    logic [19:0]   pwm_cnt_reg;
    logic [19:0]   width_reg;

    logic          btn_edge;
    logic          single_cw;
    logic          single_ccw;
    logic          tc;
    logic [8:0]    up9;
    logic [8:0]    dn9;
    logic [7:0]    angle_next;
    logic          dir_next;
    logic [19:0]   width_now;

    always_comb begin
        btn_edge   = mode_btn & ~mode_btn_reg;
        single_cw  = cw & ~ccw;
        single_ccw = ccw & ~cw;
        tc         = (sweep_cnt_reg == SW_LAST);
        up9        = {1'b0, angle_reg} + A_STEP9;
        // Bit 8 of the 9-bit difference is the borrow, i.e. the request underflowed 0.
        dn9        = {1'b0, angle_reg} - A_STEP9;
        angle_next = angle_reg;
        dir_next   = dir_reg;

        if (state_reg == MANUAL) begin
            if (single_cw) begin
                angle_next = (up9 > {1'b0, A_MAX}) ? A_MAX : up9[7:0];
                dir_next   = 1'b1;
            end else if (single_ccw) begin
                angle_next = dn9[8] ? 8'd0 : dn9[7:0];
                dir_next   = 1'b0;
            end
        end else begin
            if (single_cw) begin
                dir_next = 1'b1;
            end else if (single_ccw) begin
                dir_next = 1'b0;
            end
            // An encoder pulse on the terminal count steers that very step.
            if (tc) begin
                if (dir_next) begin
                    if (angle_reg == A_MAX) begin
                        dir_next   = 1'b0;
                        angle_next = A_MAX - 8'd1;
                    end else begin
                        angle_next = angle_reg + 8'd1;
                    end
                end else begin
                    if (angle_reg == 8'd0) begin
                        dir_next   = 1'b1;
                        angle_next = 8'd1;
                    end else begin
                        angle_next = angle_reg - 8'd1;
                    end
                end
            end
        end

        // Width is latched only at frame start, so mid-frame angle changes cannot cut a pulse.
        width_now = (pwm_cnt_reg == 20'd0) ? (P_MIN + 20'(angle_reg) * P_DEG) : width_reg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= MANUAL;
            mode_btn_reg  <= 1'b0;
            sweep_cnt_reg <= '0;
            angle_reg     <= A_MID;
            dir_reg       <= 1'b1;
            step_reg      <= 1'b0;
            pwm_cnt_reg   <= '0;
            width_reg     <= P_MIN + 20'(A_MID) * P_DEG;
            pwm_reg       <= 1'b0;
        end else begin
            mode_btn_reg <= mode_btn;
            angle_reg    <= angle_next;
            dir_reg      <= dir_next;
            step_reg     <= (angle_next != angle_reg);

            if (btn_edge) begin
                state_reg <= (state_reg == MANUAL) ? SWEEP : MANUAL;
            end

            if ((state_reg == SWEEP) && !btn_edge) begin
                sweep_cnt_reg <= tc ? '0 : sweep_cnt_reg + 1'b1;
            end else begin
                sweep_cnt_reg <= '0;
            end

            pwm_cnt_reg <= (pwm_cnt_reg == P_LAST) ? 20'd0 : pwm_cnt_reg + 20'd1;
            width_reg   <= width_now;
            pwm_reg     <= (pwm_cnt_reg < width_now);
        end
    end

    assign angle      = angle_reg;
    assign sweep_mode = (state_reg == SWEEP);
    assign dir        = dir_reg;
    assign step       = step_reg;
    assign pwm        = pwm_reg;
endmodule

// File: tb/tb_radar_sweep_ctrl.sv
// Directed and random checks of radar_sweep_ctrl against a cycle-level behavioural model.
module tb_radar_sweep_ctrl;
    localparam int AMAX  = 180;
    localparam int ASTEP = 1;
    localparam int SDIV  = 4;
    localparam int PPER  = 2000;
    localparam int PMIN  = 100;
    localparam int PDEG  = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cw = 1'b0;
    logic       ccw = 1'b0;
    logic       mode_btn = 1'b0;
    logic [7:0] angle;
    logic       sweep_mode;
    logic       dir;
    logic       step;
    logic       pwm;

    int total = 0;
    int bad = 0;
    int strobes;

    // Behavioural reference state
    int m_angle, m_dir, m_sweep, m_timer, m_btn, m_step;
    int m_pcnt, m_width, m_pwm;

    always #5 clk = ~clk;

    radar_sweep_ctrl #(
        .ANGLE_MAX(AMAX), .ANGLE_STEP(ASTEP), .SWEEP_DIV(SDIV),
        .PWM_PERIOD(PPER), .PWM_MIN(PMIN), .PWM_PER_DEG(PDEG)
    ) dut (
        .clk(clk), .reset(reset), .cw(cw), .ccw(ccw), .mode_btn(mode_btn),
        .angle(angle), .sweep_mode(sweep_mode), .dir(dir), .step(step), .pwm(pwm)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_angle = AMAX / 2; m_dir = 1; m_sweep = 0; m_timer = 0; m_btn = 0; m_step = 0;
        m_pcnt = 0; m_width = PMIN + (AMAX / 2) * PDEG; m_pwm = 0;
    endtask

    task automatic model_step(input int c, input int cc, input int b);
        int old;
        bit edge_seen;
        old = m_angle;
        edge_seen = (b != 0) && (m_btn == 0);
        m_btn = b;
        // Servo frame: width picked from the angle held at frame start
        if (m_pcnt == 0) m_width = PMIN + m_angle * PDEG;
        m_pwm = (m_pcnt < m_width) ? 1 : 0;
        m_pcnt = (m_pcnt + 1) % PPER;
        if (m_sweep == 0) begin
            if (c && !cc) begin
                m_angle = (m_angle + ASTEP > AMAX) ? AMAX : m_angle + ASTEP;
                m_dir = 1;
            end else if (cc && !c) begin
                m_angle = (m_angle - ASTEP < 0) ? 0 : m_angle - ASTEP;
                m_dir = 0;
            end
        end else begin
            if (c && !cc) m_dir = 1;
            if (cc && !c) m_dir = 0;
            m_timer++;
            if (m_timer == SDIV) begin
                m_timer = 0;
                if (m_dir == 1 && m_angle == AMAX) begin m_dir = 0; m_angle = AMAX - 1; end
                else if (m_dir == 0 && m_angle == 0) begin m_dir = 1; m_angle = 1; end
                else m_angle = m_angle + (m_dir ? 1 : -1);
            end
        end
        if (edge_seen) begin
            m_sweep = 1 - m_sweep;
            m_timer = 0;
        end
        m_step = (m_angle != old) ? 1 : 0;
    endtask

    // One clock: drive at the falling edge, check all outputs at the next falling edge.
    task automatic cyc(input int c, input int cc, input int b);
        cw = c[0]; ccw = cc[0]; mode_btn = b[0];
        model_step(c, cc, b);
        @(posedge clk);
        @(negedge clk);
        strobes += int'(step);
        chk("angle", angle, m_angle);
        chk("dir", dir, m_dir);
        chk("step", step, m_step);
        chk("sweep_mode", sweep_mode, m_sweep);
        chk("pwm", pwm, m_pwm);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0);
    endtask

    initial begin
        int hi;
        int guard;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_angle", angle, AMAX / 2);
        chk("rst_step", step, 0);
        chk("rst_dir", dir, 1);
        chk("rst_pwm", pwm, 0);
        reset = 1'b0;
        model_reset();
        strobes = 0;
        $display("step: reset released angle=%0d", angle);

        // First frame pulse width
        hi = 0;
        repeat (PPER) begin
            cyc(0, 0, 0);
            hi += int'(pwm);
        end
        chk("frame_high", hi, PMIN + (AMAX / 2) * PDEG);
        $display("step: first frame high cycles=%0d", hi);

        // MANUAL cw pulses and upper saturation
        strobes = 0;
        repeat (5) begin cyc(1, 0, 0); idle(9); end
        chk("cw5_angle", angle, 95);
        chk("cw5_strobes", strobes, 5);
        chk("cw5_dir", dir, 1);
        strobes = 0;
        repeat (100) begin cyc(1, 0, 0); idle(2); end
        chk("sat_angle", angle, AMAX);
        chk("sat_strobes", strobes, 85);
        $display("step: manual cw angle=%0d", angle);

        // Lower boundary and simultaneous cw/ccw
        repeat (179) cyc(0, 1, 0);
        chk("down_angle", angle, 1);
        cyc(1, 0, 0);
        cyc(0, 1, 0);
        strobes = 0;
        cyc(1, 1, 0);
        chk("both_angle", angle, 1);
        chk("both_step", strobes, 0);
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        chk("low_angle", angle, 0);
        chk("low_strobes", strobes, 1);
        chk("low_dir", dir, 0);
        $display("step: lower limit angle=%0d dir=%0d", angle, dir);

        // SWEEP reversal at the top limit
        repeat (178) cyc(1, 0, 0);
        cyc(0, 0, 1);
        cyc(0, 0, 0);
        chk("sw_mode", sweep_mode, 1);
        idle(3);
        chk("sw_179", angle, 179);
        idle(4);
        chk("sw_180", angle, 180);
        idle(4);
        chk("sw_rev", angle, 179);
        chk("sw_rev_dir", dir, 0);
        idle(4);
        chk("sw_178", angle, 178);
        $display("step: sweep reversal angle=%0d dir=%0d", angle, dir);

        // Encoder steering in SWEEP, then exit with coincident cw
        idle(1);
        cyc(1, 0, 0);
        chk("steer_cw_dir", dir, 1);
        chk("steer_cw_angle", angle, 178);
        cyc(0, 1, 0);
        chk("steer_ccw_dir", dir, 0);
        chk("steer_ccw_angle", angle, 178);
        cyc(0, 0, 0);
        chk("steer_next", angle, 177);
        cyc(1, 0, 1);
        chk("exit_dir", dir, 1);
        chk("exit_mode", sweep_mode, 0);
        chk("exit_angle", angle, 177);
        cyc(0, 0, 0);
        $display("step: sweep steering exit angle=%0d", angle);

        // Random stimulus against the model
        repeat (600) begin
            cyc(($urandom_range(0, 3) == 0) ? 1 : 0, ($urandom_range(0, 3) == 0) ? 1 : 0,
                ($urandom_range(0, 9) == 0) ? 1 : 0);
        end
        $display("step: random phase angle=%0d mode=%0d", angle, sweep_mode);

        // Asynchronous reset while sweeping with pwm high
        if (sweep_mode == 1'b0) begin
            cyc(0, 0, 1);
            cyc(0, 0, 0);
        end
        guard = 0;
        while (!(pwm && angle != 8'(AMAX / 2)) && guard < 3 * PPER) begin
            cyc(0, 0, 0);
            guard++;
        end
        chk("pre_rst_found", (guard < 3 * PPER) ? 1 : 0, 1);
        chk("pre_rst_mode", sweep_mode, 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_angle", angle, AMAX / 2);
        chk("arst_mode", sweep_mode, 0);
        chk("arst_pwm", pwm, 0);
        chk("arst_step", step, 0);
        chk("arst_dir", dir, 1);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        idle(20);
        $display("step: async reset angle=%0d pwm=%0d", angle, pwm);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/radar_sweep_ctrl.md
Name: radar_sweep_ctrl

Overview:
Controls the radar sensor's pointing angle. The encoder block supplies one-cycle cw/ccw pulses, and a pushbutton toggles between two modes. In MANUAL mode the encoder moves the angle directly. In SWEEP mode an internal timer steps the angle back and forth between the limits, and the encoder only sets the sweep direction. The block outputs the current angle and a step strobe, and drives the servo PWM.

Parameters:
ANGLE_MAX, 180, upper angle limit in degrees (lower limit is 0); must be ≤ 255.
ANGLE_STEP, 1, degrees moved per encoder pulse in MANUAL mode.
SWEEP_DIV, 500000, clk cycles per sweep step (10 ms at 50 MHz); must be ≥ 2.
PWM_PERIOD, 1000000, servo frame length in clk cycles (20 ms).
PWM_MIN, 50000, pulse width at angle 0 in clk cycles (1 ms).
PWM_PER_DEG, 278, additional pulse-width cycles per degree.

Ports:
clk  in  1  50 MHz system clock
reset  in  1  asynchronous, active-high reset
cw  in  1  one-cycle clockwise pulse from the encoder block
ccw  in  1  one-cycle counter-clockwise pulse from the encoder block
mode_btn  in  1  mode button; level input, already synchronized and debounced, active-high
angle  out  8  current angle, 0..ANGLE_MAX
sweep_mode  out  1  1 = SWEEP, 0 = MANUAL
dir  out  1  1 = angle increasing, 0 = angle decreasing
step  out  1  one-cycle strobe, high on the cycle angle takes a new value
pwm  out  1  servo drive signal

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values, applied immediately on reset assertion:
  - angle = ANGLE_MAX/2, i.e. 90 at defaults.
  - sweep_mode = 0, dir = 1, step = 0, pwm = 0.
  - Sweep counter, PWM counter and mode_btn edge register all cleared.
  - Latched pulse width = PWM_MIN + (ANGLE_MAX/2)*PWM_PER_DEG.
- Mode FSM, states MANUAL and SWEEP:
  - A rising edge of mode_btn (registered compare) toggles the state.
  - Entering SWEEP clears the sweep counter and keeps angle and dir unchanged.
  - Entering MANUAL holds angle.
  - cw/ccw arriving in the same cycle as the edge are evaluated under the pre-toggle state.
- MANUAL mode:
  - cw alone: angle <= min(angle + ANGLE_STEP, ANGLE_MAX); dir <= 1.
  - ccw alone: angle <= max(angle − ANGLE_STEP, 0); dir <= 0.
  - Saturation arithmetic is computed at 9-bit width so the result never wraps.
  - cw and ccw in the same cycle: ignored, no change to angle or dir.
  - The sweep counter is held at 0.
- SWEEP mode:
  - The sweep counter runs 0..SWEEP_DIV−1 and wraps to 0.
  - On the terminal count, angle moves by 1 degree in the direction of dir.
  - If dir = 1 and angle = ANGLE_MAX: dir <= 0 and angle <= ANGLE_MAX−1 (reversal with no dwell).
  - If dir = 0 and angle = 0: dir <= 1 and angle <= 1.
  - cw sets dir <= 1 and ccw sets dir <= 0; neither changes angle or resets the sweep counter.
  - cw and ccw together are ignored.
  - If a cw/ccw pulse coincides with the terminal count, the new dir applies to that step.
- step and latency:
  - angle and step update on the clk edge that samples the cause (1-cycle latency from cw/ccw or from the terminal count).
  - step = 1 only when the new angle differs from the old angle; a saturated request produces no step.
- PWM:
  - A 20-bit counter runs 0..PWM_PERIOD−1 and wraps.
  - At count 0, width <= PWM_MIN + angle*PWM_PER_DEG (20-bit result).
  - pwm = 1 while count < width, registered.
  - Angle changes mid-frame take effect at the next frame start; no glitches or runt pulses.
- Reset during operation: all state returns to reset values at once. The first PWM frame after reset release starts at count 0.

Test Plan:
1. Release reset → angle = 90, step = 0. The first frame has pwm high for exactly 75020 cycles, then low until cycle 1000000.
2. MANUAL mode, 5 cw pulses spaced 10 cycles apart → angle = 95, 5 step strobes, dir = 1. Then 100 more cw pulses → angle = 180 with only 85 further strobes.
3. MANUAL mode, angle = 1: cw and ccw in the same cycle → no change, no strobe. Then 2 ccw pulses → angle = 0 with 1 strobe, dir = 0.
4. SWEEP_DIV = 4, enter SWEEP at angle 178 with dir = 1 → angle reads 179, 180, 179, 178 at 4-cycle intervals; dir = 0 from the 179-after-180 step.
5. SWEEP mode: ccw pulse mid-interval → dir = 0 next cycle, angle unchanged, and the next step is decrementing. A mode_btn rising edge in the same cycle as a cw pulse → cw only sets dir, then state = MANUAL.
6. Assert reset while in SWEEP and during the pwm high phase → outputs immediately angle = 90, sweep_mode = 0, pwm = 0, with no clk edge required.
